store_capture_fifo: RTL and testbench

//   Bus-side observer placed directly downstream of the processor top's data-memory write port.

---
 rtl/store_capture_fifo.sv | 171 +++++++++++++++++
 tb/tb_store_capture_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : store_capture_fifo
//  Description : Observes the data-memory write port, queues in-window stores
//                in a FIFO and raises sticky done/pass/fail on the end store.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_capture_fifo #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] WIN_LO    = 32'd0,
    parameter logic [31:0] WIN_HI    = 32'd255,
    parameter logic [31:0] DONE_ADDR = 32'd100,
    parameter logic [31:0] DONE_DATA = 32'd7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    input  logic                     pop_ready,
    output logic                     pop_valid,
    output logic [31:0]              pop_addr,
    output logic [31:0]              pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done,
    output logic                     pass,
    output logic                     fail
);

    localparam int                   c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]     c_FULL    = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]     c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_stateNxt;

    logic [31:0]          r_memAddr [DEPTH];
    logic [31:0]          r_memData [DEPTH];
    logic [c_PTR_W-1:0]   r_rdPtr;
    logic [c_PTR_W-1:0]   r_wrPtr;
    logic [c_PTR_W:0]     r_count;
    logic [31:0]          r_popAddr;
    logic [31:0]          r_popData;
    logic                 r_overflow;
    logic                 r_done;
    logic                 r_pass;
    logic                 r_fail;

    logic                 w_active;
    logic                 w_inWin;
    logic                 w_qualify;
    logic                 w_doneHit;
    logic                 w_full;
    logic                 w_popFire;
    logic                 w_push;
    logic                 w_drop;
    logic [c_PTR_W-1:0]   w_rdNxt;
    logic [c_PTR_W-1:0]   w_wrNxt;
    logic [c_PTR_W:0]     w_countNxt;
    logic [31:0]          w_headAddr;
    logic [31:0]          w_headData;

    // Lower bound written as {a,1} > {lo,0} (== a >= lo) so WIN_LO = 0 is not a constant compare.
    assign w_inWin   = ({DataAdr, 1'b1} > {WIN_LO, 1'b0}) && (DataAdr <= WIN_HI);
    assign w_active  = (r_state != ST_DONE);
    assign w_qualify = MemWrite && w_inWin && w_active;
    assign w_doneHit = MemWrite && (DataAdr == DONE_ADDR) && w_active;

    assign w_full    = (r_count == c_FULL);
    assign pop_valid = (r_count != '0);
    assign w_popFire = pop_valid && pop_ready;
    assign w_push    = w_qualify && (!w_full || w_popFire);
    assign w_drop    = w_qualify && w_full && !w_popFire;

    assign w_rdNxt   = w_popFire ? (r_rdPtr + c_PTR_ONE) : r_rdPtr;
    assign w_wrNxt   = w_push    ? (r_wrPtr + c_PTR_ONE) : r_wrPtr;

    always_comb begin
        w_countNxt = r_count;
        if (w_push && !w_popFire) begin
            w_countNxt = r_count + c_CNT_ONE;
        end else if (!w_push && w_popFire) begin
            w_countNxt = r_count - c_CNT_ONE;
        end
    end

    // Next head is the store being written this edge when it lands in the head slot.
    always_comb begin
        w_headAddr = '0;
        w_headData = '0;
        if (w_countNxt != '0) begin
            if (w_push && (w_rdNxt == r_wrPtr)) begin
                w_headAddr = DataAdr;
                w_headData = WriteData;
            end else begin
                w_headAddr = r_memAddr[w_rdNxt];
                w_headData = r_memData[w_rdNxt];
            end
        end
    end

    always_comb begin
        w_stateNxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_doneHit)      w_stateNxt = ST_DONE;
                else if (w_qualify) w_stateNxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_doneHit)      w_stateNxt = ST_DONE;
            end
            ST_DONE:                w_stateNxt = ST_DONE;
            default:                w_stateNxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memAddr[r_wrPtr] <= DataAdr;
            r_memData[r_wrPtr] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_popAddr  <= '0;
            r_popData  <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_stateNxt;
            r_rdPtr    <= w_rdNxt;
            r_wrPtr    <= w_wrNxt;
            r_count    <= w_countNxt;
            r_popAddr  <= w_headAddr;
            r_popData  <= w_headData;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_doneHit) begin
                r_done <= 1'b1;
                r_pass <= (WriteData == DONE_DATA);
                r_fail <= (WriteData != DONE_DATA);
            end
        end
    end

    assign pop_addr = r_popAddr;
    assign pop_data = r_popData;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign done     = r_done;
    assign pass     = r_pass;
    assign fail     = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_store_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_capture_fifo
//  Description : Scoreboard bench for store_capture_fifo with default params.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_capture_fifo;

    localparam int DEPTH = 8;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        MemWrite  = 1'b0;
    logic [31:0] DataAdr   = '0;
    logic [31:0] WriteData = '0;
    logic        pop_ready = 1'b0;
    logic        pop_valid;
    logic [31:0] pop_addr;
    logic [31:0] pop_data;
    logic [3:0]  count;
    logic        overflow;
    logic        done;
    logic        pass;
    logic        fail;

    logic [63:0] sbq [$];
    int          nTests = 0;
    int          nFail  = 0;

    store_capture_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .pop_ready (pop_ready),
        .pop_valid (pop_valid),
        .pop_addr  (pop_addr),
        .pop_data  (pop_data),
        .count     (count),
        .overflow  (overflow),
        .done      (done),
        .pass      (pass),
        .fail      (fail)
    );

    always #5 clk = ~clk;

    // Called at a falling edge: retire the head against the scoreboard, then drive one cycle.
    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic pr);
        logic [63:0] exp;
        if (pop_valid && pr) begin
            nTests++;
            if (sbq.size() == 0) begin
                nFail++;
                $display("FAIL pop_unexpected: got addr=%h data=%h, required no entry", pop_addr, pop_data);
            end else begin
                exp = sbq.pop_front();
                if ({pop_addr, pop_data} !== exp) begin
                    nFail++;
                    $display("FAIL pop_entry: got addr=%h data=%h, required addr=%h data=%h",
                             pop_addr, pop_data, exp[63:32], exp[31:0]);
                end
            end
        end
        MemWrite  = mw;
        DataAdr   = a;
        WriteData = d;
        pop_ready = pr;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int budget = 4 * DEPTH;
        while (sbq.size() != 0 && budget > 0) begin
            step(1'b0, 32'd0, 32'd0, 1'b1);
            budget--;
        end
        step(1'b0, 32'd0, 32'd0, 1'b0);
        nTests++;
        if (sbq.size() != 0 || pop_valid !== 1'b0 || count !== 4'd0) begin
            nFail++;
            $display("FAIL %s_drain: got left=%0d pop_valid=%b count=%0d, required 0/0/0",
                     tag, sbq.size(), pop_valid, count);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        MemWrite  = 1'b0;
        pop_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sbq.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        nTests++;
        if ({count, pop_valid, overflow, done, pass, fail} !== 9'd0 || {pop_addr, pop_data} !== 64'd0) begin
            nFail++;
            $display("FAIL reset_initial: got count=%0d pv=%b ov=%b d/p/f=%b%b%b, required all 0",
                     count, pop_valid, overflow, done, pass, fail);
        end
        step(1'b1, 32'd20, 32'h5, 1'b0);
        step(1'b1, 32'd100, 32'd7, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        nTests++;
        if (count !== 4'd2 || done !== 1'b1) begin
            nFail++;
            $display("FAIL reset_precond: got count=%0d done=%b, required 2/1", count, done);
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            nTests++;
            if ({count, pop_valid, overflow, done, pass, fail} !== 9'd0) begin
                nFail++;
                $display("FAIL reset_low_%0d: got count=%0d pv=%b ov=%b d/p/f=%b%b%b, required all 0",
                         i, count, pop_valid, overflow, done, pass, fail);
            end
            if (i < 3) @(negedge clk);
        end
        reset = 1'b1;
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        nTests++;
        if ({count, pop_valid, overflow, done, pass, fail} !== 9'd0) begin
            nFail++;
            $display("FAIL reset_release: got count=%0d pv=%b ov=%b d/p/f=%b%b%b, required all 0",
                     count, pop_valid, overflow, done, pass, fail);
        end
    endtask

    task automatic test_pass();
        do_reset();
        step(1'b1, 32'd96, 32'h11, 1'b1);
        sbq.push_back({32'd96, 32'h11});
        step(1'b1, 32'd100, 32'd7, 1'b1);
        sbq.push_back({32'd100, 32'd7});
        drain("pass");
        nTests++;
        if ({done, pass, fail} !== 3'b110) begin
            nFail++;
            $display("FAIL pass_flags: got d/p/f=%b%b%b, required 110", done, pass, fail);
        end
    endtask

    task automatic test_fail();
        do_reset();
        step(1'b1, 32'd100, 32'd3, 1'b0);
        sbq.push_back({32'd100, 32'd3});
        step(1'b0, 32'd0, 32'd0, 1'b0);
        nTests++;
        if ({done, pass, fail} !== 3'b101) begin
            nFail++;
            $display("FAIL fail_flags: got d/p/f=%b%b%b, required 101", done, pass, fail);
        end
        step(1'b1, 32'd100, 32'd7, 1'b0);
        step(1'b1, 32'd40, 32'd9, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        nTests++;
        if ({done, pass, fail} !== 3'b101 || count !== 4'd1) begin
            nFail++;
            $display("FAIL fail_after_done: got d/p/f=%b%b%b count=%0d, required 101 count=1",
                     done, pass, fail, count);
        end
        drain("fail");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 32'(i * 4), 32'h100 + 32'(i), 1'b0);
            if (i < DEPTH) sbq.push_back({32'(i * 4), 32'h100 + 32'(i)});
        end
        step(1'b0, 32'd0, 32'd0, 1'b0);
        nTests++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
            nFail++;
            $display("FAIL overflow_full: got count=%0d overflow=%b, required 8/1", count, overflow);
        end
        drain("overflow");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'd8 + 32'(i), 32'hA0 + 32'(i), 1'b0);
            sbq.push_back({32'd8 + 32'(i), 32'hA0 + 32'(i)});
        end
        step(1'b1, 32'd200, 32'hABC, 1'b1);
        sbq.push_back({32'd200, 32'hABC});
        step(1'b0, 32'd0, 32'd0, 1'b0);
        nTests++;
        if (count !== 4'd8 || overflow !== 1'b0) begin
            nFail++;
            $display("FAIL full_push_pop: got count=%0d overflow=%b, required 8/0", count, overflow);
        end
        nTests++;
        if (pop_valid !== 1'b1 || pop_addr !== 32'd9) begin
            nFail++;
            $display("FAIL full_stable_head: got pv=%b addr=%h, required 1/00000009", pop_valid, pop_addr);
        end
        drain("full");
    endtask

    task automatic test_window();
        do_reset();
        step(1'b1, 32'h1000, 32'd5, 1'b0);
        step(1'b1, 32'd256, 32'd6, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        nTests++;
        if (count !== 4'd0 || pop_valid !== 1'b0 || done !== 1'b0) begin
            nFail++;
            $display("FAIL window_outside: got count=%0d pv=%b done=%b, required 0/0/0",
                     count, pop_valid, done);
        end
        step(1'b1, 32'd255, 32'hFF, 1'b0);
        sbq.push_back({32'd255, 32'hFF});
        step(1'b1, 32'd0, 32'h1, 1'b0);
        sbq.push_back({32'd0, 32'h1});
        step(1'b0, 32'd0, 32'd0, 1'b0);
        nTests++;
        if (count !== 4'd2) begin
            nFail++;
            $display("FAIL window_edges: got count=%0d, required 2", count);
        end
        drain("window");
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_overflow();
        test_back_to_back();
        test_window();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
